// File: rtl/sdram_ch2_arbiter_if.sv
// Client-side and ch2-side signal bundle for sdram_ch2_arbiter.
// The slave modport is the arbiter's view; master is the clients plus the SDRAM controller.
interface sdram_ch2_arbiter_if #(
  parameter int NUM_CLI = 3
);
  logic [NUM_CLI-1:0]    cli_req;
  logic [NUM_CLI-1:0]    cli_we;
  logic [NUM_CLI*21-1:0] cli_addr;
  logic [NUM_CLI*16-1:0] cli_din;
  logic [NUM_CLI*2-1:0]  cli_be;
  logic [NUM_CLI-1:0]    cli_ack;
  logic [15:0]           cli_dout;
  logic                  cli_err;

  logic [20:0]           mem_addr;
  logic [15:0]           mem_din;
  logic [1:0]            mem_wr;
  logic                  mem_rd;
  logic                  mem_rdy;
  logic [15:0]           mem_dout;

  modport slave (
    input  cli_req, cli_we, cli_addr, cli_din, cli_be, mem_rdy, mem_dout,
    output cli_ack, cli_dout, cli_err, mem_addr, mem_din, mem_wr, mem_rd
  );

  modport master (
    output cli_req, cli_we, cli_addr, cli_din, cli_be, mem_rdy, mem_dout,
    input  cli_ack, cli_dout, cli_err, mem_addr, mem_din, mem_wr, mem_rd
  );
endinterface

// File: rtl/sdram_ch2_arbiter.sv
// Shares the SDRAM chip-2 port among NUM_CLI level req/ack clients, one strobed access at a time.
// Round-robin by default; define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (client 0 highest).
module sdram_ch2_arbiter #(
  parameter int NUM_CLI = 3,
  parameter int RD_LAT  = 12,
  parameter int BUSY_TO = 15
) (
  input  logic               clk,
  input  logic               reset,
  sdram_ch2_arbiter_if.slave bus,
  output logic [1:0]         grant_id
);

  localparam int CNT_MAX = (RD_LAT > BUSY_TO) ? RD_LAT : BUSY_TO;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_DATA_WAIT, S_ACK, S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         grant_q, grant_d;
  logic               we_q, we_d;
  logic [20:0]        mem_addr_q, mem_addr_d;
  logic [15:0]        mem_din_q, mem_din_d;
  logic [1:0]         mem_wr_q, mem_wr_d;
  logic               mem_rd_q, mem_rd_d;
  logic [15:0]        cli_dout_q, cli_dout_d;
  logic [NUM_CLI-1:0] cli_ack_q, cli_ack_d;
  logic               cli_err_q, cli_err_d;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
  logic [1:0]         rr_q, rr_d;
`endif

  logic               pick_vld;
  logic [1:0]         pick_idx;
  logic               pick_we;
  logic [20:0]        pick_addr;
  logic [15:0]        pick_din;
  logic [1:0]         pick_be;
  logic               go_ack;
  logic               timed_out;

  // The lowest search offset is visited last so it wins among requesting clients.
  always_comb begin
    int tgt;
    // NOTE: every combinational output gets a default first, so no path leaves a latch.
    tgt       = 0;
    pick_vld  = 1'b0;
    pick_idx  = '0;
    pick_we   = 1'b0;
    pick_addr = '0;
    pick_din  = '0;
    pick_be   = '0;
    for (int k = NUM_CLI - 1; k >= 0; k--) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      tgt = k;
`else
      tgt = int'(rr_q) + k;
      if (tgt >= NUM_CLI) tgt = tgt - NUM_CLI;
`endif
      for (int i = 0; i < NUM_CLI; i++) begin
        if (bus.cli_req[i] && (i == tgt)) begin
          pick_vld = 1'b1;
          pick_idx = 2'(i);
        end
      end
    end
    for (int i = 0; i < NUM_CLI; i++) begin
      if (pick_idx == 2'(i)) begin
        pick_we   = bus.cli_we[i];
        pick_addr = bus.cli_addr[21*i +: 21];
        pick_din  = bus.cli_din[16*i +: 16];
        pick_be   = bus.cli_be[2*i +: 2];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    we_d       = we_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_wr_d   = mem_wr_q;
    mem_rd_d   = mem_rd_q;
    cli_dout_d = cli_dout_q;
    cli_ack_d  = '0;
    cli_err_d  = 1'b0;
    go_ack     = 1'b0;
    timed_out  = 1'b0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    rr_d       = rr_q;
`endif
    case (state_q)
      // Strobes are registered here so they are already high during ISSUE.
      S_IDLE: begin
        if (pick_vld) begin
          grant_d    = pick_idx;
          we_d       = pick_we;
          mem_addr_d = pick_addr;
          mem_din_d  = pick_din;
          if (pick_we) mem_wr_d = (pick_be == 2'b00) ? 2'b11 : pick_be;
          else         mem_rd_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!bus.mem_rdy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TO - 1)) begin
          go_ack    = 1'b1;
          timed_out = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (bus.mem_rdy) begin
          if (we_q) begin
            go_ack = 1'b1;
          end else begin
            cnt_d   = CNT_W'(RD_LAT);
            state_d = S_DATA_WAIT;
          end
        end
      end
      // Capturing as the count reaches zero lands cli_dout exactly RD_LAT+1 cycles after mem_rdy rises.
      S_DATA_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          cli_dout_d = bus.mem_dout;
          go_ack     = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ACK: begin
`ifndef SDRAM_ARB_FIXED_PRIO_EN
        rr_d = (grant_q == 2'(NUM_CLI - 1)) ? 2'b00 : grant_q + 2'b01;
`endif
        state_d = S_GAP;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (go_ack) begin
      state_d   = S_ACK;
      mem_wr_d  = 2'b00;
      mem_rd_d  = 1'b0;
      cli_err_d = timed_out;
      for (int i = 0; i < NUM_CLI; i++) cli_ack_d[i] = (grant_q == 2'(i));
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      grant_q    <= '0;
      we_q       <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_wr_q   <= '0;
      mem_rd_q   <= 1'b0;
      cli_dout_q <= 16'hFFFF;
      cli_ack_q  <= '0;
      cli_err_q  <= 1'b0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      rr_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      we_q       <= we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_wr_q   <= mem_wr_d;
      mem_rd_q   <= mem_rd_d;
      cli_dout_q <= cli_dout_d;
      cli_ack_q  <= cli_ack_d;
      cli_err_q  <= cli_err_d;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      rr_q       <= rr_d;
`endif
    end
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.mem_wr   = mem_wr_q;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.cli_ack  = cli_ack_q;
  assign bus.cli_dout = cli_dout_q;
  assign bus.cli_err  = cli_err_q;
  assign grant_id     = grant_q;

endmodule
